// File: rtl/bp_zynq_cfg_loader_pkg.sv
// Shared definitions for the BlackParrot boot-time config loader.
//   - FSM state encoding
//   - Per-core config-bus register offsets and entry count
//   - Helper mapping an entry index to its register offset
package bp_zynq_cfg_loader_pkg;

  typedef enum logic [2:0] {
    e_idle,
    e_config,
    e_unfreeze,
    e_drain,
    e_done
  } bp_zynq_cfg_loader_state_e;

  localparam logic [15:0] freeze_offset_gp      = 16'h0008;
  localparam logic [15:0] npc_offset_gp         = 16'h0010;
  localparam logic [15:0] icache_mode_offset_gp = 16'h0018;
  localparam logic [15:0] dcache_mode_offset_gp = 16'h0020;

  localparam int unsigned entries_per_core_gp = 4;
  localparam int unsigned entry_idx_width_gp  = 2;

  // Entry order within a core's config phase: freeze, npc, icache, dcache.
  function automatic logic [15:0] cfg_reg_offset(input logic [entry_idx_width_gp-1:0] k);
    logic [15:0] off;
    case (k)
      2'd0:    off = freeze_offset_gp;
      2'd1:    off = npc_offset_gp;
      2'd2:    off = icache_mode_offset_gp;
      default: off = dcache_mode_offset_gp;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/bp_zynq_cfg_loader_if.sv
// Config write port between the loader (master) and the shell's cfg
// write path (slave).
//   mem_v_o          master->slave  request valid
//   mem_addr_o       master->slave  write address
//   mem_data_o       master->slave  write data
//   mem_ready_and_i  slave->master  request accepted when high with mem_v_o
//   mem_resp_v_i     slave->master  write acknowledge, consumed same cycle
interface bp_zynq_cfg_loader_if #(
  parameter int paddr_width_p = 34,
  parameter int data_width_p  = 64
);

  logic                     mem_v_o;
  logic [paddr_width_p-1:0] mem_addr_o;
  logic [data_width_p-1:0]  mem_data_o;
  logic                     mem_ready_and_i;
  logic                     mem_resp_v_i;

  modport master (
    output mem_v_o, mem_addr_o, mem_data_o,
    input  mem_ready_and_i, mem_resp_v_i
  );

  modport slave (
    input  mem_v_o, mem_addr_o, mem_data_o,
    output mem_ready_and_i, mem_resp_v_i
  );

endinterface

// File: rtl/bp_zynq_cfg_loader_credits.sv
// Up/down counter of outstanding (accepted but unacknowledged) writes.
//   clk_i, reset_i  clock, synchronous active-high reset
//   inc_i           a write was accepted this cycle
//   dec_i           a write acknowledge arrived this cycle
//   full_o          count == max_credits_p, no further issue allowed
//   empty_o         count == 0
//   spurious_o      acknowledge with nothing outstanding; count held at 0
module bp_zynq_cfg_loader_credits #(
  parameter int max_credits_p = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o,
  output logic spurious_o
);

  localparam int cnt_width_lp = $clog2(max_credits_p + 1);

  logic [cnt_width_lp-1:0] count_q, count_d;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == cnt_width_lp'(max_credits_p));

  // An ack landing in the same cycle as an issue pairs with it, so it is
  // never spurious even when the counter is empty.
  always_comb begin
    count_d    = count_q;
    spurious_o = dec_i & ~inc_i & empty_o;
    if (inc_i & ~dec_i) begin
      count_d = count_q + cnt_width_lp'(1);
    end else if (dec_i & ~inc_i & ~empty_o) begin
      count_d = count_q - cnt_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bp_zynq_cfg_loader.sv
// Boot-time sequencer: writes freeze/npc/icache_mode/dcache_mode for every
// core through one credit-limited write port, then clears freeze on every
// core, waits for all acks and reports done.
//   clk_i, reset_i  clock, synchronous active-high reset
//   start_i         start pulse, honoured only in idle or done
//   busy_o          sequence in progress (config, unfreeze, drain)
//   done_o          all writes issued and acknowledged
//   error_o         sticky: ack received with no write outstanding
//   mem             config write port (master side)
module bp_zynq_cfg_loader
  import bp_zynq_cfg_loader_pkg::*;
#(
  parameter int                       num_core_p       = 1,
  parameter int                       paddr_width_p    = 34,
  parameter int                       data_width_p     = 64,
  parameter logic [paddr_width_p-1:0] cfg_base_addr_p  = 34'h0_0020_0000,
  parameter int                       core_stride_lg_p = 24,
  parameter logic [data_width_p-1:0]  boot_pc_p        = 64'h0000_0000_8000_0000,
  parameter int                       max_credits_p    = 4
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o,
  bp_zynq_cfg_loader_if.master      mem
);

  localparam int core_w_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1;

  bp_zynq_cfg_loader_state_e       state_q, state_d;
  logic [core_w_lp-1:0]            c_q, c_d;
  logic [entry_idx_width_gp-1:0]   k_q, k_d;
  logic                            error_q, error_d;

  logic                     handshake;
  logic                     last_core;
  logic                     last_entry;
  logic                     credits_full;
  logic                     credits_empty;
  logic                     credit_spurious;
  logic [paddr_width_p-1:0] core_base;

  bp_zynq_cfg_loader_credits #(
    .max_credits_p(max_credits_p)
  ) credits (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .inc_i     (handshake),
    .dec_i     (mem.mem_resp_v_i),
    .full_o    (credits_full),
    .empty_o   (credits_empty),
    .spurious_o(credit_spurious)
  );

  assign busy_o  = (state_q == e_config) || (state_q == e_unfreeze) || (state_q == e_drain);
  assign done_o  = (state_q == e_done);
  assign error_o = error_q;

  assign mem.mem_v_o = ((state_q == e_config) || (state_q == e_unfreeze)) && !credits_full;
  assign handshake   = mem.mem_v_o & mem.mem_ready_and_i;

  assign last_core  = (c_q == core_w_lp'(num_core_p - 1));
  assign last_entry = (k_q == entry_idx_width_gp'(entries_per_core_gp - 1));
  assign core_base  = cfg_base_addr_p + (paddr_width_p'(c_q) << core_stride_lg_p);

  // Address/data are purely a function of state/c/k, so they hold while a
  // request is stalled on mem_ready_and_i.
  always_comb begin
    mem.mem_addr_o = '0;
    mem.mem_data_o = '0;
    case (state_q)
      e_config: begin
        mem.mem_addr_o = core_base + paddr_width_p'(cfg_reg_offset(k_q));
        mem.mem_data_o = (k_q == entry_idx_width_gp'(1)) ? boot_pc_p : data_width_p'(1);
      end
      e_unfreeze: begin
        mem.mem_addr_o = core_base + paddr_width_p'(freeze_offset_gp);
        mem.mem_data_o = '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    k_d     = k_q;
    error_d = error_q;

    case (state_q)
      e_idle, e_done: begin
        if (start_i) begin
          state_d = e_config;
          c_d     = '0;
          k_d     = '0;
          error_d = 1'b0;
        end
      end
      e_config: begin
        if (handshake) begin
          if (last_entry) begin
            k_d = '0;
            if (last_core) begin
              c_d     = '0;
              state_d = e_unfreeze;
            end else begin
              c_d = c_q + core_w_lp'(1);
            end
          end else begin
            k_d = k_q + entry_idx_width_gp'(1);
          end
        end
      end
      e_unfreeze: begin
        if (handshake) begin
          if (last_core) begin
            c_d     = '0;
            state_d = e_drain;
          end else begin
            c_d = c_q + core_w_lp'(1);
          end
        end
      end
      e_drain: begin
        if (credits_empty) begin
          state_d = e_done;
        end
      end
      default: state_d = e_idle;
    endcase

    // Stray acks outside a run (e.g. left over from before a reset) are dropped.
    if (busy_o && credit_spurious) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_idle;
      c_q     <= '0;
      k_q     <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      k_q     <= k_d;
      error_q <= error_d;
    end
  end

endmodule
